ir_packet_tx_param: RTL and testbench

- Parametrised successor of the car IR packet transmitter.
- Emits one packet per request: START burst, CAR_SELECT burst, then NUM_CMD command bursts, each burst followed by a GAP. All bursts are modulated by a 50%-duty carrier.
- Latches the command at packet start and provides a BUSY/PACKET_DONE handshake toward the bus interface.
- Optional auto-repeat mode. Sits between the bus-side command register and the IR LED pin.

---
 rtl/ir_packet_tx_param.sv | 124 ++++++++++++
 tb/tb_ir_packet_tx_param.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ir_packet_tx_param.sv
// ir_packet_tx_param: carrier-modulated IR car packet transmitter (START, CAR_SELECT, NUM_CMD command bursts, each followed by a GAP); auto-repeat with HOLDOFF enabled by IRTX_AUTO_REPEAT_EN
module ir_packet_tx_param #(
  parameter int CLK_RATIO      = 1250,
  parameter int START_BURST    = 88,
  parameter int CARSEL_BURST   = 22,
  parameter int GAP_LEN        = 40,
  parameter int ASSERT_BURST   = 44,
  parameter int DEASSERT_BURST = 22,
  parameter int NUM_CMD        = 4,
  parameter int HOLDOFF_LEN    = 4000
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_CMD-1:0]        i_command,
  input  logic                      i_send_packet,
  input  logic                      i_repeat,
  output logic                      o_busy,
  output logic                      o_packet_done,
  output logic                      o_ir_led,
  output logic [2:0]                o_state,
  output logic [$clog2(NUM_CMD):0]  o_cmd_idx
);
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
  localparam int CW = $clog2(CLK_RATIO);
  localparam int MAXLEN = max2(max2(max2(START_BURST, CARSEL_BURST), max2(GAP_LEN, ASSERT_BURST)),
                               max2(DEASSERT_BURST, HOLDOFF_LEN));
  localparam int PW = $clog2(MAXLEN + 1);
  localparam int IW = $clog2(NUM_CMD) + 1;
  localparam logic [CW-1:0] CAR_LAST = CW'(CLK_RATIO - 1);
  localparam logic [CW-1:0] CAR_HALF = CW'(CLK_RATIO / 2);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    GAP     = 3'd2,
    CARSEL  = 3'd3,
    CMD     = 3'd4,
    HOLDOFF = 3'd5
  } state_t;
  state_t            r_state;
  state_t            r_prev;
  logic [CW-1:0]     r_car_cnt;
  logic [PW-1:0]     r_per_cnt;
  logic [NUM_CMD-1:0] r_cmd_reg;
  logic [IW-1:0]     r_cmd_idx;
  logic              r_ir_led;
  logic [NUM_CMD-1:0] w_cmd_sh;
  logic [PW-1:0]     w_len_last;
  logic              w_tick;
  logic              w_end;
  logic              w_last_cmd;
  logic              w_clr;
  logic              w_rpt;
`ifdef IRTX_AUTO_REPEAT_EN
  assign w_rpt = i_repeat;
`else
  logic w_unused;
  assign w_rpt    = 1'b0;
  assign w_unused = i_repeat;
`endif
  assign w_cmd_sh   = r_cmd_reg >> r_cmd_idx;
  assign w_len_last = r_state == START   ? PW'(START_BURST - 1)  :
                      r_state == CARSEL  ? PW'(CARSEL_BURST - 1) :
                      r_state == CMD     ? (w_cmd_sh[0] ? PW'(ASSERT_BURST - 1) : PW'(DEASSERT_BURST - 1)) :
                      r_state == HOLDOFF ? PW'(HOLDOFF_LEN - 1)  :
                                           PW'(GAP_LEN - 1);
  assign w_tick     = r_car_cnt == CAR_LAST;
  assign w_end      = w_tick && r_per_cnt == w_len_last;
  assign w_last_cmd = r_prev == CMD && r_cmd_idx == IW'(NUM_CMD - 1);
  assign w_clr      = r_state == IDLE || w_end || (r_state == HOLDOFF && !w_rpt) || r_state > HOLDOFF;
  assign o_busy        = r_state != IDLE;
  assign o_packet_done = r_state == GAP && w_end && w_last_cmd;
  assign o_ir_led      = r_ir_led;
  assign o_state       = r_state;
  assign o_cmd_idx     = r_cmd_idx;
  // packet sequencer: carrier/period counters, state transitions, command latch and LED drive
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_prev    <= IDLE;
      r_car_cnt <= '0;
      r_per_cnt <= '0;
      r_cmd_reg <= '0;
      r_cmd_idx <= '0;
      r_ir_led  <= 1'b0;
    end else begin
      r_ir_led  <= (r_state == START || r_state == CARSEL || r_state == CMD) && r_car_cnt < CAR_HALF;
      r_car_cnt <= (w_clr || w_tick) ? '0 : r_car_cnt + 1'b1;
      r_per_cnt <= w_clr ? '0 : w_tick ? r_per_cnt + 1'b1 : r_per_cnt;
      case (r_state)
        IDLE:
          if (i_send_packet) begin
            r_state   <= START;
            r_cmd_reg <= i_command;
            r_cmd_idx <= '0;
          end
        START, CARSEL, CMD:
          if (w_end) begin
            r_state <= GAP;
            r_prev  <= r_state;
          end
        GAP:
          if (w_end) begin
            if (r_prev == START) r_state <= CARSEL;
            else if (r_prev == CARSEL) begin
              r_state   <= CMD;
              r_cmd_idx <= '0;
            end else if (!w_last_cmd) begin
              r_state   <= CMD;
              r_cmd_idx <= r_cmd_idx + 1'b1;
            end else r_state <= w_rpt ? HOLDOFF : IDLE;
          end
        HOLDOFF:
          if (!w_rpt) r_state <= IDLE;
          else if (w_end) begin
            r_state   <= START;
            r_cmd_reg <= i_command;
            r_cmd_idx <= '0;
          end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ir_packet_tx_param.sv
// tb_ir_packet_tx_param: scoreboard bench for ir_packet_tx_param; auto-repeat scenario built when IRTX_AUTO_REPEAT_EN is defined
module tb_ir_packet_tx_param;
  localparam int CR = 4;
  localparam int NC = 4;
  typedef struct {
    int           len;
    logic [127:0] burst;
  } pkt_t;
  logic clk = 1'b0, rst_n = 1'b0, send = 1'b0, rpt = 1'b0;
  logic [NC-1:0] cmd = '0;
  logic busy, done, led;
  logic [2:0] state;
  logic [$clog2(NC):0] idx;
  pkt_t q[$];
  pkt_t cur;
  int starts[$];
  int n_chk = 0, n_err = 0, tcyc = 0, cyc = 0, led_err = 0, busy_cnt = 0, done_total = 0;
  bit in_pkt = 1'b0, cur_ok = 1'b0;

  ir_packet_tx_param #(
    .CLK_RATIO(CR), .START_BURST(3), .CARSEL_BURST(2), .GAP_LEN(2),
    .ASSERT_BURST(2), .DEASSERT_BURST(1), .NUM_CMD(NC), .HOLDOFF_LEN(3)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_command(cmd), .i_send_packet(send), .i_repeat(rpt),
    .o_busy(busy), .o_packet_done(done), .o_ir_led(led), .o_state(state), .o_cmd_idx(idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // expected packet: burst map per carrier period and total length in clocks
  function automatic pkt_t model(input logic [NC-1:0] c);
    pkt_t e;
    int p = 0;
    e.burst = '0;
    for (int i = 0; i < 3; i++) begin e.burst[p] = 1'b1; p++; end
    p += 2;
    for (int i = 0; i < 2; i++) begin e.burst[p] = 1'b1; p++; end
    p += 2;
    for (int b = 0; b < NC; b++) begin
      for (int i = 0; i < (c[b] ? 2 : 1); i++) begin e.burst[p] = 1'b1; p++; end
      p += 2;
    end
    e.len = p * CR;
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [NC-1:0] c);
    q.push_back(model(c));
    cmd  = c;
    send = 1'b1;
    tick(1);
    send = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0 = done_total;
    int n = 0;
    while (done_total == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, int'(done_total != d0), 1);
  endtask

  // monitor: segments packets from START to PACKET_DONE and scores them against the queue head
  always @(negedge clk) begin
    tcyc++;
    if (!rst_n) in_pkt = 1'b0;
    else begin
      if (!in_pkt && state == 3'd1) begin
        in_pkt   = 1'b1;
        cyc      = 0;
        led_err  = 0;
        busy_cnt = 0;
        starts.push_back(tcyc);
        cur_ok = q.size() > 0;
        if (cur_ok) cur = q[0];
        else chk("unexpected_pkt", 1, 0);
      end
      if (in_pkt) begin
        if (led !== (cyc >= 1 && cur.burst[(cyc - 1) / CR] && ((cyc - 1) % CR) < CR / 2)) led_err++;
        if (busy) busy_cnt++;
        cyc++;
        if (done) begin
          done_total++;
          in_pkt = 1'b0;
          if (cur_ok) begin
            void'(q.pop_front());
            chk("pkt_len", cyc, cur.len);
            chk("led_wave_errs", led_err, 0);
            chk("busy_cycles", busy_cnt, cur.len);
          end
        end
      end else if (done) begin
        done_total++;
        chk("stray_done", 1, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int d0, n;
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_led", led, 0);
    chk("rst_done", done, 0);
    chk("rst_state", state, 0);
    chk("rst_idx", idx, 0);
    rst_n = 1'b1;
    tick(2);
    foreach (q[i]) ;
    send_pkt(4'b0101);
    wait_done("p0101", 200);
    tick(1);
    chk("p0101_busy_after", busy, 0);
    send_pkt(4'b0000);
    wait_done("p0000", 200);
    tick(1);
    chk("p0000_busy_after", busy, 0);
    send_pkt(4'b1111);
    wait_done("p1111", 200);
    tick(1);
    chk("p1111_busy_after", busy, 0);
    chk("p1111_idx_after", idx, NC - 1);
    send_pkt(4'b0000);
    cmd = 4'b1111;
    tick(40);
    send = 1'b1;
    tick(1);
    send = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 300);
    chk("chg_done_pulse", done, 1);
    d0 = done_total;
    send = 1'b1;
    @(posedge clk);
    #1;
    send = 1'b0;
    tick(20);
    chk("chg_no_requeue_busy", busy, 0);
    chk("chg_no_requeue_done", done_total, d0 + 1);
    send_pkt(4'b0000);
    tick(30);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!led && n < 100);
    chk("abort_led_before", led, 1);
    d0 = done_total;
    rst_n = 1'b0;
    #1;
    chk("abort_led_async", led, 0);
    chk("abort_busy_async", busy, 0);
    tick(3);
    void'(q.pop_front());
    rst_n = 1'b1;
    tick(100);
    chk("abort_no_done", done_total, d0);
    send_pkt(4'b0000);
    wait_done("post_abort", 200);
    tick(1);
    chk("post_abort_busy_after", busy, 0);
`ifdef IRTX_AUTO_REPEAT_EN
    rpt = 1'b1;
    send_pkt(4'b0000);
    wait_done("rpt1", 200);
    q.push_back(model(4'b1111));
    cmd = 4'b1111;
    tick(2);
    chk("holdoff_state", state, 5);
    chk("holdoff_busy", busy, 1);
    chk("holdoff_led", led, 0);
    n = 0;
    while (state != 3'd1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rpt2_started", state, 1);
    tick(10);
    rpt = 1'b0;
    wait_done("rpt2", 200);
    tick(1);
    chk("rpt2_busy_after", busy, 0);
    chk("rpt_spacing", starts[starts.size() - 1] - starts[starts.size() - 2], 96);
    tick(30);
    chk("rpt_stopped", busy, 0);
`else
    rpt = 1'b1;
    send_pkt(4'b0101);
    wait_done("norpt", 200);
    tick(1);
    chk("norpt_busy_after", busy, 0);
    tick(30);
    chk("norpt_state", state, 0);
    rpt = 1'b0;
`endif
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
